// File: rtl/gray_decoder.sv
// Receive end of a Gray-code counter link: converts each accepted Gray sample to binary,
// checks that every move is a single +1/-1 step, and tracks direction, wraps and errors.
module gray_decoder #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Valid,
    input  logic              Clear,
    input  logic [WIDTH-1:0]  Gray,
    output logic [WIDTH-1:0]  Binary,
    output logic              Step,
    output logic              Dir,
    output logic              Overflow,
    output logic [WRAP_W-1:0] WrapCnt,
    output logic              Error,
    output logic              Locked
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_FAULT    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    binary_q, binary_d;
    logic                step_q, step_d;
    logic                dir_q, dir_d;
    logic                overflow_q, overflow_d;
    logic [WRAP_W-1:0]   wrap_q, wrap_d;
    logic                error_q, error_d;

    logic [WIDTH-1:0]    nb;
    logic [WIDTH-1:0]    diff;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    assign nb[WIDTH-1] = Gray[WIDTH-1];
    generate
        for (genvar gi = WIDTH - 2; gi >= 0; gi--) begin : g_conv
            assign nb[gi] = nb[gi+1] ^ Gray[gi];
        end
    endgenerate

    assign diff = nb - binary_q;

    always_comb begin
        state_d    = state_q;
        binary_d   = binary_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        overflow_d = overflow_q;
        wrap_d     = wrap_q;
        error_d    = error_q;

        if (Clear) begin
            state_d    = ST_UNLOCKED;
            overflow_d = 1'b0;
            wrap_d     = '0;
            error_d    = 1'b0;
        end else if (Valid) begin
            case (state_q)
                ST_UNLOCKED: begin
                    binary_d = nb;
                    state_d  = ST_LOCKED;
                end
                ST_LOCKED: begin
                    // The +1 test comes first so a 1-bit code always counts as "up".
                    if (diff == '0) begin
                        binary_d = binary_q;
                    end else if (diff == WIDTH'(1)) begin
                        binary_d = nb;
                        step_d   = 1'b1;
                        dir_d    = 1'b1;
                        if (binary_q == '1) begin
                            overflow_d = 1'b1;
                            wrap_d     = wrap_q + WRAP_W'(1);
                        end
                    end else if (diff == '1) begin
                        binary_d = nb;
                        step_d   = 1'b1;
                        dir_d    = 1'b0;
                        if (binary_q == '0) begin
                            wrap_d = wrap_q - WRAP_W'(1);
                        end
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_UNLOCKED;
            binary_q   <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            overflow_q <= 1'b0;
            wrap_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            binary_q   <= binary_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            overflow_q <= overflow_d;
            wrap_q     <= wrap_d;
            error_q    <= error_d;
        end
    end

    assign Binary   = binary_q;
    assign Step     = step_q;
    assign Dir      = dir_q;
    assign Overflow = overflow_q;
    assign WrapCnt  = wrap_q;
    assign Error    = error_q;
    assign Locked   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_gray_decoder.sv
// Directed-vector bench for gray_decoder (WIDTH=3, WRAP_W=8) with hand-computed expectations.
module tb_gray_decoder;

    logic       clk;
    logic       reset;
    logic       valid;
    logic       clear;
    logic [2:0] gray;
    logic [2:0] binary;
    logic       step;
    logic       dir;
    logic       overflow;
    logic [7:0] wrap_cnt;
    logic       error;
    logic       locked;

    int n_vec = 0;
    int n_err = 0;

    gray_decoder #(.WIDTH(3), .WRAP_W(8)) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Valid    (valid),
        .Clear    (clear),
        .Gray     (gray),
        .Binary   (binary),
        .Step     (step),
        .Dir      (dir),
        .Overflow (overflow),
        .WrapCnt  (wrap_cnt),
        .Error    (error),
        .Locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Drive one edge worth of inputs, then sample just after the edge.
    task automatic cycle(input logic r, input logic c, input logic v, input logic [2:0] g);
        @(negedge clk);
        reset = r;
        clear = c;
        valid = v;
        gray  = g;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, " binary"},   32'(binary),   32'd0);
        check_eq({tag, " step"},     32'(step),     32'd0);
        check_eq({tag, " dir"},      32'(dir),      32'd0);
        check_eq({tag, " overflow"}, 32'(overflow), 32'd0);
        check_eq({tag, " wrapcnt"},  32'(wrap_cnt), 32'd0);
        check_eq({tag, " error"},    32'(error),    32'd0);
        check_eq({tag, " locked"},   32'(locked),   32'd0);
    endtask

    logic [2:0] up_seq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                               3'b111, 3'b101, 3'b100, 3'b000};

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        valid = 1'b0;
        gray  = 3'b000;

        // 1: reset, then a full upward lap ending in a forward wrap
        cycle(1'b1, 1'b0, 1'b0, 3'b000);
        check_reset_state("t1 reset");
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 1'b1, up_seq[i]);
            check_eq($sformatf("t1 binary[%0d]", i), 32'(binary), 32'(i % 8));
            check_eq($sformatf("t1 step[%0d]", i), 32'(step), (i == 0) ? 32'd0 : 32'd1);
            if (i > 0) check_eq($sformatf("t1 dir[%0d]", i), 32'(dir), 32'd1);
            check_eq($sformatf("t1 overflow[%0d]", i), 32'(overflow), (i == 8) ? 32'd1 : 32'd0);
        end
        check_eq("t1 wrapcnt", 32'(wrap_cnt), 32'd1);
        check_eq("t1 error",   32'(error),    32'd0);
        check_eq("t1 locked",  32'(locked),   32'd1);

        // 2: repeat sample and idles change nothing
        cycle(1'b0, 1'b0, 1'b1, 3'b001);
        cycle(1'b0, 1'b0, 1'b1, 3'b011);
        check_eq("t2 binary at 011", 32'(binary), 32'd2);
        cycle(1'b0, 1'b0, 1'b1, 3'b011);
        check_eq("t2 repeat binary", 32'(binary), 32'd2);
        check_eq("t2 repeat step",   32'(step),   32'd0);
        check_eq("t2 repeat error",  32'(error),  32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 3'b111);
            check_eq($sformatf("t2 idle binary[%0d]", i), 32'(binary), 32'd2);
            check_eq($sformatf("t2 idle step[%0d]", i),   32'(step),   32'd0);
            check_eq($sformatf("t2 idle error[%0d]", i),  32'(error),  32'd0);
        end

        // 6: Clear beats a same-cycle Valid; Overflow/WrapCnt still 1 from test 1
        check_eq("t6 pre overflow", 32'(overflow), 32'd1);
        check_eq("t6 pre wrapcnt",  32'(wrap_cnt), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 3'b001);
        check_eq("t6 overflow", 32'(overflow), 32'd0);
        check_eq("t6 wrapcnt",  32'(wrap_cnt), 32'd0);
        check_eq("t6 locked",   32'(locked),   32'd0);
        check_eq("t6 binary",   32'(binary),   32'd2);

        // 3: backward wrap from 0 to 7
        cycle(1'b1, 1'b0, 1'b0, 3'b000);
        cycle(1'b0, 1'b0, 1'b1, 3'b000);
        cycle(1'b0, 1'b0, 1'b1, 3'b100);
        check_eq("t3 binary",   32'(binary),   32'd7);
        check_eq("t3 step",     32'(step),     32'd1);
        check_eq("t3 dir",      32'(dir),      32'd0);
        check_eq("t3 overflow", 32'(overflow), 32'd0);
        check_eq("t3 wrapcnt",  32'(wrap_cnt), 32'hFF);

        // 4: illegal jump, FAULT ignores Valid, Clear recovers
        cycle(1'b1, 1'b0, 1'b0, 3'b000);
        cycle(1'b0, 1'b0, 1'b1, 3'b000);
        cycle(1'b0, 1'b0, 1'b1, 3'b001);
        cycle(1'b0, 1'b0, 1'b1, 3'b010);
        check_eq("t4 jump error",  32'(error),  32'd1);
        check_eq("t4 jump locked", 32'(locked), 32'd0);
        check_eq("t4 jump binary", 32'(binary), 32'd1);
        check_eq("t4 jump step",   32'(step),   32'd0);
        cycle(1'b0, 1'b0, 1'b1, 3'b011);
        check_eq("t4 fault binary", 32'(binary), 32'd1);
        check_eq("t4 fault error",  32'(error),  32'd1);
        cycle(1'b0, 1'b1, 1'b0, 3'b000);
        check_eq("t4 clear error",  32'(error),  32'd0);
        check_eq("t4 clear locked", 32'(locked), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 3'b110);
        check_eq("t4 relock binary", 32'(binary), 32'd4);
        check_eq("t4 relock locked", 32'(locked), 32'd1);
        check_eq("t4 relock step",   32'(step),   32'd0);

        // 5: Reset mid-stream drops the same-cycle sample
        cycle(1'b1, 1'b0, 1'b0, 3'b000);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, up_seq[i]);
        check_eq("t5 binary at 101", 32'(binary), 32'd6);
        cycle(1'b1, 1'b0, 1'b1, 3'b100);
        check_reset_state("t5 reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
